// File: rtl/gearbox_param.sv
// Width converter: repacks an IN_W-bit stream into OUT_W-bit words MSB-first,
// with valid/ready on both sides and a zero-padded, keep-masked frame flush.
module gearbox_param #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 32,
  localparam int unsigned KW   = OUT_W / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  data_in,
  input  logic             data_in_last,
  input  logic             data_en,
  output logic             data_in_rdy,
  output logic [OUT_W-1:0] data_out,
  output logic [KW-1:0]    data_out_keep,
  output logic             data_out_last,
  output logic             data_out_en,
  input  logic             data_out_rdy
);

  localparam int unsigned BW = IN_W + OUT_W;
  localparam int unsigned CW = $clog2(BW + 1);
  localparam logic [CW-1:0] OUT_C = CW'(OUT_W);
  localparam logic [CW-1:0] IN_C  = CW'(IN_W);

  typedef enum logic {FILL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    buf_q, buf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    consumed, pos;
  logic [BW-1:0]    shifted;
  logic             accept, fire;
  logic             en_d, last_d;
  logic [KW-1:0]    keep_d;

  // Ready depends only on registered state and reset, never on data_out_rdy.
  always_comb begin
    data_in_rdy = !reset && (state_q == FILL) && (cnt_q <= OUT_C);
  end

  // Shift out the fired word first, then insert the accepted word below the survivors.
  always_comb begin
    accept   = data_en && data_in_rdy;
    fire     = data_out_en && data_out_rdy;
    consumed = fire ? ((cnt_q < OUT_C) ? cnt_q : OUT_C) : '0;
    shifted  = fire ? (buf_q << OUT_W) : buf_q;
    pos      = cnt_q - consumed;
    buf_d    = shifted;
    cnt_d    = pos;
    state_d  = state_q;
    if (accept) begin
      buf_d = shifted | ({data_in, {OUT_W{1'b0}}} >> pos);
      cnt_d = pos + IN_C;
      if (data_in_last) state_d = FLUSH;
    end
    if ((state_q == FLUSH) && fire && (cnt_q <= OUT_C)) state_d = FILL;
  end

  // Output qualifiers for the next cycle, derived from the next buffer state.
  always_comb begin
    en_d   = (cnt_d >= OUT_C) || ((state_d == FLUSH) && (cnt_d != '0));
    last_d = (state_d == FLUSH) && (cnt_d != '0) && (cnt_d <= OUT_C);
    keep_d = '0;
    if (en_d) begin
      if (last_d) begin
        for (int j = 0; j < KW; j++) begin
          keep_d[KW-1-j] = (32'(cnt_d) >= 32'(8 * (j + 1)));
        end
      end else begin
        keep_d = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      buf_q         <= '0;
      cnt_q         <= '0;
      data_out      <= '0;
      data_out_keep <= '0;
      data_out_last <= 1'b0;
      data_out_en   <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      data_out      <= buf_d[BW-1 -: OUT_W];
      data_out_keep <= keep_d;
      data_out_last <= last_d;
      data_out_en   <= en_d;
    end
  end

endmodule

// File: tb/tb_gearbox_param.sv
// Directed and randomised checks of gearbox_param across several width pairs.
module tb_gearbox_param;

  localparam int NI = 5;
  localparam int unsigned IWS [NI] = '{24, 32, 8, 128, 64};
  localparam int unsigned OWS [NI] = '{32, 24, 128, 8, 24};

  logic         clk;
  logic         reset;
  logic [127:0] din    [NI];
  logic         dlast  [NI];
  logic         den    [NI];
  logic         ordy   [NI];
  logic         in_rdy [NI];
  logic         olast  [NI];
  logic         oen    [NI];
  logic [127:0] dout_w [NI];
  logic [15:0]  keep_w [NI];

  int checks = 0;
  int errors = 0;

  logic [127:0] inq  [$];
  bit           inlq [$];
  logic [127:0] oq_d [$];
  logic [15:0]  oq_k [$];
  bit           oq_l [$];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned IWG = IWS[g];
    localparam int unsigned OWG = OWS[g];
    logic [OWG-1:0]   dout;
    logic [OWG/8-1:0] keep;
    gearbox_param #(.IN_W(IWG), .OUT_W(OWG)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (din[g][IWG-1:0]),
      .data_in_last (dlast[g]),
      .data_en      (den[g]),
      .data_in_rdy  (in_rdy[g]),
      .data_out     (dout),
      .data_out_keep(keep),
      .data_out_last(olast[g]),
      .data_out_en  (oen[g]),
      .data_out_rdy (ordy[g])
    );
    assign dout_w[g] = 128'(dout);
    assign keep_w[g] = 16'(keep);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    inq.delete(); inlq.delete();
    oq_d.delete(); oq_k.delete(); oq_l.delete();
  endtask

  // Streams inq into DUT g and collects fired output words; rnd adds random gaps and stalls.
  task automatic run_io(input int g, input bit rnd, input int max_cyc);
    int cyc = 0;
    int idle = 0;
    bit stall_pend = 0;
    logic [127:0] sd = '0;
    logic [15:0]  sk = '0;
    bit           sl = 0;
    while (cyc < max_cyc && !(inq.size() == 0 && idle >= 4)) begin
      if (stall_pend) begin
        checks++;
        if (oen[g] !== 1'b1 || dout_w[g] !== sd || keep_w[g] !== sk || olast[g] !== sl) begin
          errors++;
          $display("FAIL stall_stable g=%0d got en=%b d=%h k=%h l=%b want en=1 d=%h k=%h l=%b",
                   g, oen[g], dout_w[g], keep_w[g], olast[g], sd, sk, sl);
        end
      end
      if (inq.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
        den[g] = 1'b1; din[g] = inq[0]; dlast[g] = inlq[0];
      end else begin
        den[g]   = 1'b0;
        din[g]   = rnd ? {$urandom, $urandom, $urandom, $urandom} : '0;
        dlast[g] = rnd ? 1'($urandom_range(1)) : 1'b0;
      end
      ordy[g] = !rnd || ($urandom_range(2) != 0);
      if (den[g] && in_rdy[g]) begin
        void'(inq.pop_front()); void'(inlq.pop_front());
      end
      if (oen[g] && ordy[g]) begin
        oq_d.push_back(dout_w[g]); oq_k.push_back(keep_w[g]); oq_l.push_back(olast[g]);
      end
      stall_pend = oen[g] && !ordy[g];
      sd = dout_w[g]; sk = keep_w[g]; sl = olast[g];
      idle = (inq.size() == 0 && !oen[g]) ? idle + 1 : 0;
      tick();
      cyc++;
    end
    den[g] = 1'b0; dlast[g] = 1'b0;
    checks++;
    if (!(inq.size() == 0 && idle >= 4)) begin
      errors++;
      $display("FAIL run_timeout g=%0d got pending=%0d want pending=0", g, inq.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (oen[g] !== 1'b0 || keep_w[g] !== 16'h0 || olast[g] !== 1'b0 ||
          dout_w[g] !== 128'h0 || in_rdy[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state g=%0d got en=%b k=%h l=%b d=%h rdy=%b want all 0",
                 g, oen[g], keep_w[g], olast[g], dout_w[g], in_rdy[g]);
      end
    end
    reset = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      checks++;
      if (in_rdy[g] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_rdy g=%0d got %b want 1", g, in_rdy[g]);
      end
    end
  endtask

  task automatic test_stream();
    logic [127:0] ed [3] = '{128'h11223344, 128'h55667788, 128'h99AABBCC};
    bit           el [3] = '{1'b0, 1'b0, 1'b1};
    clear_q();
    inq  = '{128'h112233, 128'h445566, 128'h778899, 128'hAABBCC};
    inlq = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_io(0, 1'b0, 200);
    checks++;
    if (oq_d.size() != 3) begin
      errors++;
      $display("FAIL stream_count got %0d want 3", oq_d.size());
    end
    for (int i = 0; i < 3 && i < oq_d.size(); i++) begin
      checks++;
      if (oq_d[i] !== ed[i] || oq_k[i] !== 16'hF || oq_l[i] !== el[i]) begin
        errors++;
        $display("FAIL stream_word%0d got d=%h k=%h l=%b want d=%h k=f l=%b",
                 i, oq_d[i], oq_k[i], oq_l[i], ed[i], el[i]);
      end
    end
  endtask

  task automatic test_short_frame();
    logic [127:0] ed [2] = '{128'h11223344, 128'h55660000};
    logic [15:0]  ek [2] = '{16'hF, 16'hC};
    bit           el [2] = '{1'b0, 1'b1};
    clear_q();
    inq.push_back(128'h112233); inlq.push_back(1'b1);
    run_io(0, 1'b0, 100);
    checks++;
    if (oq_d.size() != 1 || oq_d[0] !== 128'h11223300 || oq_k[0] !== 16'hE || oq_l[0] !== 1'b1) begin
      errors++;
      $display("FAIL short_single got n=%0d d=%h k=%h l=%b want n=1 d=11223300 k=e l=1",
               oq_d.size(), (oq_d.size() > 0) ? oq_d[0] : 128'h0,
               (oq_k.size() > 0) ? oq_k[0] : 16'h0, (oq_l.size() > 0) ? oq_l[0] : 1'b0);
    end
    checks++;
    if (in_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL short_rdy_return got %b want 1", in_rdy[0]);
    end
    clear_q();
    inq  = '{128'h112233, 128'h445566};
    inlq = '{1'b0, 1'b1};
    run_io(0, 1'b0, 100);
    checks++;
    if (oq_d.size() != 2) begin
      errors++;
      $display("FAIL short_two_count got %0d want 2", oq_d.size());
    end
    for (int i = 0; i < 2 && i < oq_d.size(); i++) begin
      checks++;
      if (oq_d[i] !== ed[i] || oq_k[i] !== ek[i] || oq_l[i] !== el[i]) begin
        errors++;
        $display("FAIL short_two_word%0d got d=%h k=%h l=%b want d=%h k=%h l=%b",
                 i, oq_d[i], oq_k[i], oq_l[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] ed [3] = '{128'h11223344, 128'h55667788, 128'h99AABBCC};
    bit           el [3] = '{1'b0, 1'b0, 1'b1};
    ordy[0] = 1'b0;
    den[0] = 1'b1; din[0] = 128'h112233; dlast[0] = 1'b0;
    checks++;
    if (in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL bp_rdy_cnt0 got %b want 1", in_rdy[0]);
    end
    tick();
    din[0] = 128'h445566;
    checks++;
    if (in_rdy[0] !== 1'b1) begin
      errors++; $display("FAIL bp_rdy_cnt24 got %b want 1", in_rdy[0]);
    end
    tick();
    den[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_rdy[0] !== 1'b0 || oen[0] !== 1'b1 || dout_w[0] !== 128'h11223344) begin
        errors++;
        $display("FAIL bp_hold%0d got rdy=%b en=%b d=%h want rdy=0 en=1 d=11223344",
                 i, in_rdy[0], oen[0], dout_w[0]);
      end
      tick();
    end
    clear_q();
    inq  = '{128'h778899, 128'hAABBCC};
    inlq = '{1'b0, 1'b1};
    run_io(0, 1'b0, 200);
    checks++;
    if (oq_d.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d want 3", oq_d.size());
    end
    for (int i = 0; i < 3 && i < oq_d.size(); i++) begin
      checks++;
      if (oq_d[i] !== ed[i] || oq_k[i] !== 16'hF || oq_l[i] !== el[i]) begin
        errors++;
        $display("FAIL bp_word%0d got d=%h k=%h l=%b want d=%h k=f l=%b",
                 i, oq_d[i], oq_k[i], oq_l[i], ed[i], el[i]);
      end
    end
  endtask

  task automatic test_narrow();
    logic [127:0] ed [2] = '{128'hAABBCC, 128'hDD0000};
    logic [15:0]  ek [2] = '{16'h7, 16'h4};
    bit           el [2] = '{1'b0, 1'b1};
    clear_q();
    inq.push_back(128'hAABBCCDD); inlq.push_back(1'b1);
    run_io(1, 1'b0, 100);
    checks++;
    if (oq_d.size() != 2) begin
      errors++; $display("FAIL narrow_count got %0d want 2", oq_d.size());
    end
    for (int i = 0; i < 2 && i < oq_d.size(); i++) begin
      checks++;
      if (oq_d[i] !== ed[i] || oq_k[i] !== ek[i] || oq_l[i] !== el[i]) begin
        errors++;
        $display("FAIL narrow_word%0d got d=%h k=%h l=%b want d=%h k=%h l=%b",
                 i, oq_d[i], oq_k[i], oq_l[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ed [2] = '{128'h01020304, 128'h05060000};
    logic [15:0]  ek [2] = '{16'hF, 16'hC};
    bit           el [2] = '{1'b0, 1'b1};
    ordy[0] = 1'b0;
    den[0] = 1'b1; din[0] = 128'hA1A2A3; dlast[0] = 1'b0;
    tick();
    din[0] = 128'hB1B2B3;
    tick();
    den[0] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (oen[0] !== 1'b0 || keep_w[0] !== 16'h0 || olast[0] !== 1'b0 ||
        dout_w[0] !== 128'h0 || in_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got en=%b k=%h l=%b d=%h rdy=%b want en=0 k=0 l=0 d=0 rdy=1",
               oen[0], keep_w[0], olast[0], dout_w[0], in_rdy[0]);
    end
    clear_q();
    inq  = '{128'h010203, 128'h040506};
    inlq = '{1'b0, 1'b1};
    run_io(0, 1'b0, 100);
    checks++;
    if (oq_d.size() != 2) begin
      errors++; $display("FAIL mid_count got %0d want 2", oq_d.size());
    end
    for (int i = 0; i < 2 && i < oq_d.size(); i++) begin
      checks++;
      if (oq_d[i] !== ed[i] || oq_k[i] !== ek[i] || oq_l[i] !== el[i]) begin
        errors++;
        $display("FAIL mid_word%0d got d=%h k=%h l=%b want d=%h k=%h l=%b",
                 i, oq_d[i], oq_k[i], oq_l[i], ed[i], ek[i], el[i]);
      end
    end
  endtask

  // Random frames on every width pair, checked against a byte-stream reference.
  task automatic test_random();
    logic [127:0] exp_d [$];
    logic [15:0]  exp_k [$];
    bit           exp_l [$];
    for (int g = 0; g < NI; g++) begin
      int ib = int'(IWS[g]) / 8;
      int ob = int'(OWS[g]) / 8;
      clear_q();
      exp_d.delete(); exp_k.delete(); exp_l.delete();
      for (int f = 0; f < 6; f++) begin
        logic [7:0] bytes [$];
        int nb = $urandom_range(5, 1);
        for (int b = 0; b < nb; b++) begin
          logic [127:0] beat = '0;
          for (int k = 0; k < ib; k++) begin
            logic [7:0] by = 8'($urandom_range(255));
            bytes.push_back(by);
            beat = (beat << 8) | 128'(by);
          end
          inq.push_back(beat);
          inlq.push_back(b == nb - 1);
        end
        for (int i = 0; i < bytes.size(); i += ob) begin
          logic [127:0] w = '0;
          logic [15:0]  kp = '0;
          for (int j = 0; j < ob; j++) begin
            w  = (w << 8) | ((i + j < bytes.size()) ? 128'(bytes[i + j]) : 128'h0);
            kp = (kp << 1) | 16'(i + j < bytes.size());
          end
          exp_d.push_back(w); exp_k.push_back(kp); exp_l.push_back(i + ob >= bytes.size());
        end
      end
      run_io(g, 1'b1, 5000);
      checks++;
      if (oq_d.size() != exp_d.size()) begin
        errors++;
        $display("FAIL rand_count g=%0d got %0d want %0d", g, oq_d.size(), exp_d.size());
      end
      for (int i = 0; i < exp_d.size() && i < oq_d.size(); i++) begin
        checks++;
        if (oq_d[i] !== exp_d[i] || oq_k[i] !== exp_k[i] || oq_l[i] !== exp_l[i]) begin
          errors++;
          $display("FAIL rand_word g=%0d i=%0d got d=%h k=%h l=%b want d=%h k=%h l=%b",
                   g, i, oq_d[i], oq_k[i], oq_l[i], exp_d[i], exp_k[i], exp_l[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      din[g] = '0; dlast[g] = 1'b0; den[g] = 1'b0; ordy[g] = 1'b0;
    end
    test_reset();
    test_stream();
    test_short_frame();
    test_backpressure();
    test_narrow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
